range_counter: RTL and testbench
================================

Name: range_counter

Overview:
Parametrised up/down range counter, next generation of the team's basic counter block. Counts within an arbitrary [COUNT_FROM, COUNT_TO] window with a configurable step and direction, and selectable wrap or saturate at the bounds. A one-shot mode stops the counter at the terminal bound. A registered terminal-count pulse supports timers, address generators and pacing logic.

Parameters:
DATA_WIDTH, 8, width of count and preload data
COUNT_FROM, 0, lower bound of count window; reset value
COUNT_TO, 2**DATA_WIDTH-1, upper bound of count window (inclusive)
STEP, 1, increment/decrement magnitude per enabled cycle
WRAP, 1, 1 = wrap to opposite bound on crossing; 0 = saturate at bound

Ports:
clk  input  1  single clock, all logic on posedge
rst_n  input  1  synchronous reset, active low
en  input  1  count enable
dir  input  1  1 = count up, 0 = count down
preload  input  1  load input_data (clamped) into counter
input_data  input  DATA_WIDTH  preload value
oneshot  input  1  1 = stop at terminal bound instead of wrap/saturate
out_data  output  DATA_WIDTH  registered count value
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  high while stopped in one-shot DONE state

Behaviour:
- Reset (rst_n=0 at posedge): out_data=COUNT_FROM, tc=0, done=0, state=CNT_COUNT. Reset has top priority and overrides preload and en.
- Priority per cycle: rst_n, then preload, then en. With none active, out_data holds and tc=0.
- Preload: out_data = clamp(input_data, COUNT_FROM, COUNT_TO). State returns to CNT_COUNT, done=0, tc=0. Preload wins over en in the same cycle.
- FSM states: CNT_COUNT, CNT_DONE.
- CNT_DONE: en is ignored and out_data holds. Exits to CNT_COUNT only on preload or reset.
- Arithmetic in CNT_COUNT with en=1: compute next = out_data ± STEP in DATA_WIDTH+1 bits, so there is no silent modular overflow.
- Terminal event: up with out_data+STEP > COUNT_TO, or down with out_data < COUNT_FROM+STEP.
- Non-terminal step: out_data = next, tc=0.
- Terminal with oneshot=1: out_data = bound in the direction of travel (COUNT_TO up, COUNT_FROM down), tc=1, state moves to CNT_DONE, done=1 from the next cycle.
- Terminal with oneshot=0, WRAP=1: out_data = opposite bound (COUNT_FROM going up, COUNT_TO going down), tc=1.
- Terminal with oneshot=0, WRAP=0: out_data = bound in the direction of travel. tc=1 only if out_data was not already at that bound; repeated enables at the bound give tc=0.
- Latency: all outputs are registered; out_data and tc update one cycle after the sampled controls.
- dir may change on any cycle and takes effect on that cycle's step.
- Elaboration checks ($error): COUNT_FROM < COUNT_TO; STEP >= 1; STEP <= COUNT_TO-COUNT_FROM; COUNT_TO < 2**DATA_WIDTH.

Optional Feature:
Macro RANGE_COUNTER_MATCH_EN.
- Defined: adds input match_val [DATA_WIDTH] and output match [1]. match is a registered one-cycle pulse whenever out_data is updated (count step or preload) to a value equal to match_val. match is 0 on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package counter_pkg holds the typedef enum cnt_state_e {CNT_COUNT, CNT_DONE} and the clamp function used for preload.
- One combinational sub-module, range_step_calc, computes next value, terminal flag and landing value from out_data, dir, STEP and the bounds.
- The top module holds the FSM and output registers.

Test Plan:
Bench parameters: DATA_WIDTH=8, COUNT_FROM=10, COUNT_TO=20, STEP=3, WRAP=1 unless stated.
1. Reset: rst_n=0 with en=1 and preload=1 -> out_data=10, tc=0, done=0. Repeat mid-count at out_data=16 -> out_data=10 next cycle.
2. Up wrap: dir=1, en=1 from 10 -> 13, 16, 19, then 10 with tc=1 on that cycle only.
3. Down wrap: preload 12, then dir=0, en=1 -> 20 with tc=1, then 17, 14, 11.
4. Saturate (WRAP=0): preload 18, up -> 20 with tc=1; further enables hold 20 with tc=0.
5. One-shot: oneshot=1, preload 18, up -> 20, tc=1, done=1; en held 3 cycles -> 20 unchanged. Then preload 15 -> out_data=15, done=0.
6. Preload clamp and priority: input_data=250 -> 20; input_data=3 -> 10; preload=1 with en=1 and input_data=14 -> 14, no step applied.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the range counter family.
package counter_pkg;

  typedef enum logic [0:0] {
    CNT_COUNT = 1'b0,
    CNT_DONE  = 1'b1
  } cnt_state_e;

  // Saturates v into [lo, hi]; callers size operands to 32 bits.
  function automatic logic [31:0] clamp(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/range_step_calc.sv
// Combinational step evaluation: next value, terminal detection and the
// bound values the top module may land on.
module range_step_calc #(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_FROM = 0,
  parameter int COUNT_TO   = 2**DATA_WIDTH-1,
  parameter int STEP       = 1
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic                  dir,
  output logic [DATA_WIDTH-1:0] next_val,
  output logic [DATA_WIDTH-1:0] travel_bound,
  output logic [DATA_WIDTH-1:0] opp_bound,
  output logic                  terminal,
  output logic                  at_bound
);

  localparam logic [DATA_WIDTH:0]   FROM_W   = (DATA_WIDTH+1)'(COUNT_FROM);
  localparam logic [DATA_WIDTH:0]   TO_W     = (DATA_WIDTH+1)'(COUNT_TO);
  localparam logic [DATA_WIDTH:0]   STEP_W   = (DATA_WIDTH+1)'(STEP);
  localparam logic [DATA_WIDTH:0]   LIMIT_DN = FROM_W + STEP_W;
  localparam logic [DATA_WIDTH-1:0] FROM_V   = DATA_WIDTH'(COUNT_FROM);
  localparam logic [DATA_WIDTH-1:0] TO_V     = DATA_WIDTH'(COUNT_TO);

  // One extra bit so an overflowing step is seen rather than wrapped.
  logic [DATA_WIDTH:0] up_sum;
  logic [DATA_WIDTH:0] dn_diff;
  logic                unused_borrow;

  assign up_sum        = {1'b0, cur} + STEP_W;
  assign dn_diff       = {1'b0, cur} - STEP_W;
  assign unused_borrow = dn_diff[DATA_WIDTH];

  always_comb begin
    next_val     = cur;
    travel_bound = TO_V;
    opp_bound    = FROM_V;
    terminal     = 1'b0;
    if (dir) begin
      next_val     = up_sum[DATA_WIDTH-1:0];
      terminal     = (up_sum > TO_W);
      travel_bound = TO_V;
      opp_bound    = FROM_V;
    end else begin
      next_val     = dn_diff[DATA_WIDTH-1:0];
      terminal     = ({1'b0, cur} < LIMIT_DN);
      travel_bound = FROM_V;
      opp_bound    = TO_V;
    end
  end

  assign at_bound = (cur == travel_bound);

endmodule

// File: rtl/range_counter.sv
// Up/down range counter with wrap/saturate, one-shot stop and tc pulse.
// Optional match output enabled by defining RANGE_COUNTER_MATCH_EN.
//   state     | meaning
//   CNT_COUNT | counting on en, terminal handled by wrap/saturate/one-shot
//   CNT_DONE  | one-shot finished, holding until preload or reset
module range_counter
  import counter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_FROM = 0,
  parameter int COUNT_TO   = 2**DATA_WIDTH-1,
  parameter int STEP       = 1,
  parameter int WRAP       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  preload,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  oneshot,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  tc,
  output logic                  done
`ifdef RANGE_COUNTER_MATCH_EN
  ,
  input  logic [DATA_WIDTH-1:0] match_val,
  output logic                  match
`endif
);

  if (!(COUNT_FROM < COUNT_TO)) begin : g_chk_order
    $error("range_counter: COUNT_FROM must be below COUNT_TO");
  end
  if (STEP < 1) begin : g_chk_step_min
    $error("range_counter: STEP must be at least 1");
  end
  if (STEP > COUNT_TO - COUNT_FROM) begin : g_chk_step_max
    $error("range_counter: STEP exceeds window size");
  end
  if (64'(COUNT_TO) >= (64'd1 << DATA_WIDTH)) begin : g_chk_width
    $error("range_counter: COUNT_TO does not fit DATA_WIDTH");
  end

  localparam logic [DATA_WIDTH-1:0] FROM_V = DATA_WIDTH'(COUNT_FROM);

  cnt_state_e            state;
  logic [DATA_WIDTH-1:0] next_val;
  logic [DATA_WIDTH-1:0] travel_bound;
  logic [DATA_WIDTH-1:0] opp_bound;
  logic                  terminal;
  logic                  at_bound;
  logic [31:0]           clamp_wide;
  logic [DATA_WIDTH-1:0] clamp_val;

  range_step_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .COUNT_FROM (COUNT_FROM),
    .COUNT_TO   (COUNT_TO),
    .STEP       (STEP)
  ) u_step (
    .cur          (out_data),
    .dir          (dir),
    .next_val     (next_val),
    .travel_bound (travel_bound),
    .opp_bound    (opp_bound),
    .terminal     (terminal),
    .at_bound     (at_bound)
  );

  assign clamp_wide = clamp(32'(input_data), 32'(COUNT_FROM), 32'(COUNT_TO));
  assign clamp_val  = clamp_wide[DATA_WIDTH-1:0];

  // Upper bits are always zero because COUNT_TO fits in DATA_WIDTH.
  if (DATA_WIDTH < 32) begin : g_clamp_hi
    logic unused_clamp_hi;
    assign unused_clamp_hi = ^clamp_wide[31:DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= FROM_V;
      tc       <= 1'b0;
      state    <= CNT_COUNT;
`ifdef RANGE_COUNTER_MATCH_EN
      match    <= 1'b0;
`endif
    end else begin
      tc <= 1'b0;
`ifdef RANGE_COUNTER_MATCH_EN
      match <= 1'b0;
`endif
      if (preload) begin
        out_data <= clamp_val;
        state    <= CNT_COUNT;
`ifdef RANGE_COUNTER_MATCH_EN
        match    <= (clamp_val == match_val);
`endif
      end else if (en && state == CNT_COUNT) begin
        if (!terminal) begin
          out_data <= next_val;
`ifdef RANGE_COUNTER_MATCH_EN
          match    <= (next_val == match_val);
`endif
        end else if (oneshot) begin
          out_data <= travel_bound;
          tc       <= 1'b1;
          state    <= CNT_DONE;
`ifdef RANGE_COUNTER_MATCH_EN
          match    <= (travel_bound == match_val);
`endif
        end else if (WRAP != 0) begin
          out_data <= opp_bound;
          tc       <= 1'b1;
`ifdef RANGE_COUNTER_MATCH_EN
          match    <= (opp_bound == match_val);
`endif
        end else begin
          // Saturate: only the first arrival at the bound is terminal.
          out_data <= travel_bound;
          tc       <= !at_bound;
`ifdef RANGE_COUNTER_MATCH_EN
          match    <= (travel_bound == match_val);
`endif
        end
      end
    end
  end

  assign done = (state == CNT_DONE);

endmodule

// File: tb/tb_range_counter.sv
// Bench for range_counter: a wrapping and a saturating instance share stimulus
// and are compared each cycle against an integer model plus directed constants.
module tb_range_counter;

  localparam int LO = 10;
  localparam int HI = 20;
  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, preload, oneshot;
  logic [7:0] input_data;
  logic [7:0] out_w, out_s;
  logic       tc_w, tc_s, done_w, done_s;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state, index 0 = wrapping instance, 1 = saturating instance.
  int m_val  [2];
  int m_tc   [2];
  int m_done [2];

  always #5 clk = ~clk;

  range_counter #(.DATA_WIDTH(8), .COUNT_FROM(LO), .COUNT_TO(HI), .STEP(ST), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .preload(preload),
    .input_data(input_data), .oneshot(oneshot),
    .out_data(out_w), .tc(tc_w), .done(done_w)
  );

  range_counter #(.DATA_WIDTH(8), .COUNT_FROM(LO), .COUNT_TO(HI), .STEP(ST), .WRAP(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .preload(preload),
    .input_data(input_data), .oneshot(oneshot),
    .out_data(out_s), .tc(tc_s), .done(done_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: applies one clock of the counter rules to instance i.
  task automatic model_step(input int i, input bit wrap);
    int tgt, far;
    bit hit;
    if (!rst_n) begin
      m_val[i] = LO; m_tc[i] = 0; m_done[i] = 0;
    end else if (preload) begin
      m_val[i]  = (int'(input_data) < LO) ? LO : (int'(input_data) > HI) ? HI : int'(input_data);
      m_tc[i]   = 0;
      m_done[i] = 0;
    end else if (en && m_done[i] == 0) begin
      tgt  = dir ? m_val[i] + ST : m_val[i] - ST;
      far  = dir ? HI : LO;
      hit  = dir ? (tgt > HI) : (tgt < LO);
      if (!hit) begin
        m_val[i] = tgt; m_tc[i] = 0;
      end else if (oneshot) begin
        m_val[i] = far; m_tc[i] = 1; m_done[i] = 1;
      end else if (wrap) begin
        m_val[i] = dir ? LO : HI; m_tc[i] = 1;
      end else begin
        m_tc[i]  = (m_val[i] != far) ? 1 : 0;
        m_val[i] = far;
      end
    end else begin
      m_tc[i] = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    check("w_out",  int'(out_w),  m_val[0]);
    check("w_tc",   int'(tc_w),   m_tc[0]);
    check("w_done", int'(done_w), m_done[0]);
    check("s_out",  int'(out_s),  m_val[1]);
    check("s_tc",   int'(tc_s),   m_tc[1]);
    check("s_done", int'(done_s), m_done[1]);
  endtask

  initial begin
    m_val  = '{0, 0};
    m_tc   = '{0, 0};
    m_done = '{0, 0};

    // Reset overrides preload and en
    rst_n = 1'b0; en = 1'b1; preload = 1'b1; dir = 1'b1; oneshot = 1'b0; input_data = 8'd15;
    #2;
    cyc();
    check("rst_out", int'(out_w), 10);
    check("rst_tc", int'(tc_w), 0);
    check("rst_done", int'(done_w), 0);

    // Reset mid-count from 16
    rst_n = 1'b1; preload = 1'b0;
    cyc(); cyc();
    check("pre_rst16", int'(out_w), 16);
    rst_n = 1'b0;
    cyc();
    check("rst_mid", int'(out_w), 10);

    // Up wrap
    rst_n = 1'b1;
    cyc(); check("up13", int'(out_w), 13);
    cyc(); check("up16", int'(out_w), 16);
    cyc(); check("up19", int'(out_w), 19); check("up19_tc", int'(tc_w), 0);
    cyc(); check("up_wrap", int'(out_w), 10); check("up_wrap_tc", int'(tc_w), 1);
    cyc(); check("up_after", int'(out_w), 13); check("up_after_tc", int'(tc_w), 0);

    // Down wrap
    preload = 1'b1; input_data = 8'd12;
    cyc(); check("pl12", int'(out_w), 12);
    preload = 1'b0; dir = 1'b0;
    cyc(); check("dn_wrap", int'(out_w), 20); check("dn_wrap_tc", int'(tc_w), 1);
    cyc(); check("dn17", int'(out_w), 17); check("dn17_tc", int'(tc_w), 0);
    cyc(); check("dn14", int'(out_w), 14);
    cyc(); check("dn11", int'(out_w), 11);

    // Saturate on the WRAP=0 instance
    preload = 1'b1; input_data = 8'd18; dir = 1'b1;
    cyc(); check("sat_pl", int'(out_s), 18);
    preload = 1'b0;
    cyc(); check("sat20", int'(out_s), 20); check("sat20_tc", int'(tc_s), 1);
    cyc(); check("sat_hold", int'(out_s), 20); check("sat_hold_tc", int'(tc_s), 0);
    cyc(); check("sat_hold2_tc", int'(tc_s), 0);

    // One-shot
    oneshot = 1'b1; preload = 1'b1; input_data = 8'd18;
    cyc();
    preload = 1'b0;
    cyc(); check("os_out", int'(out_w), 20); check("os_tc", int'(tc_w), 1); check("os_done", int'(done_w), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); check("os_hold", int'(out_w), 20); check("os_hold_tc", int'(tc_w), 0); check("os_hold_done", int'(done_w), 1);
    end
    preload = 1'b1; input_data = 8'd15;
    cyc(); check("os_exit", int'(out_w), 15); check("os_exit_done", int'(done_w), 0);
    oneshot = 1'b0;

    // Preload clamp and priority over en
    input_data = 8'd250;
    cyc(); check("clamp_hi", int'(out_w), 20);
    input_data = 8'd3;
    cyc(); check("clamp_lo", int'(out_w), 10);
    en = 1'b1; input_data = 8'd14;
    cyc(); check("pl_prio", int'(out_w), 14); check("pl_prio_tc", int'(tc_w), 0);
    preload = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst_n      = ($urandom_range(0, 99) >= 3);
      preload    = ($urandom_range(0, 99) < 10);
      en         = ($urandom_range(0, 99) < 75);
      dir        = $urandom_range(0, 1) == 1;
      oneshot    = ($urandom_range(0, 99) < 25);
      input_data = 8'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
